// File: rtl/alu_ctrl_seq_if.sv
// Bus bundle between the ALU control sequencer and its environment:
// instruction handshake, ALU drive/return and response handshake.
interface alu_ctrl_seq_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;

  modport slave (
    input  instr_valid, opcode, funct, imm, rs_data, rt_data,
    input  alu_result, alu_zero, res_ready,
    output instr_ready, alu_op, alu_a, alu_b,
    output res_valid, result, branch_taken, illegal
  );

  modport master (
    output instr_valid, opcode, funct, imm, rs_data, rt_data,
    output alu_result, alu_zero, res_ready,
    input  instr_ready, alu_op, alu_a, alu_b,
    input  res_valid, result, branch_taken, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes one instruction, holds the ALU inputs for
// SETTLE cycles, captures the ALU result and offers it on a valid/ready port.
module alu_ctrl_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  function automatic logic [31:0] sign_ext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zero_ext(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        is_beq_q, is_beq_d;
  logic [31:0] result_q, result_d;
  logic        branch_q, branch_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  dec_op;
  logic [31:0] dec_b;
  logic        dec_beq;
  logic        dec_ill;

  always_comb begin
    dec_op  = OP_AND;
    dec_b   = bus.rt_data;
    dec_beq = 1'b0;
    dec_ill = 1'b0;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          default:   dec_ill = 1'b1;
        endcase
      end
      6'b100011, 6'b101011: begin
        dec_op = OP_ADD;
        dec_b  = sign_ext(bus.imm);
      end
      6'b001100: begin
        dec_op = OP_AND;
        dec_b  = zero_ext(bus.imm);
      end
      6'b001101: begin
        dec_op = OP_OR;
        dec_b  = zero_ext(bus.imm);
      end
      6'b000100: begin
        dec_op  = OP_BEQ;
        dec_beq = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Illegal instructions leave the ALU drive untouched and skip EXEC.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    is_beq_d  = is_beq_q;
    result_d  = result_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          if (dec_ill) begin
            illegal_d = 1'b1;
            result_d  = 32'h0;
            branch_d  = 1'b0;
            state_d   = RESP;
          end else begin
            alu_op_d  = dec_op;
            alu_a_d   = bus.rs_data;
            alu_b_d   = dec_b;
            is_beq_d  = dec_beq;
            illegal_d = 1'b0;
            cnt_d     = CNT_INIT;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = bus.alu_result;
          branch_d = is_beq_q & bus.alu_zero;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      alu_op_q  <= OP_AND;
      alu_a_q   <= 32'h0;
      alu_b_q   <= 32'h0;
      is_beq_q  <= 1'b0;
      result_q  <= 32'h0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      is_beq_q  <= is_beq_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.instr_ready  = (state_q == IDLE);
  assign bus.res_valid    = (state_q == RESP);
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.result       = result_q;
  assign bus.branch_taken = branch_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: two instances (SETTLE=1 and SETTLE=3) behind a
// behavioural ALU, directed vector table plus randomized transactions.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_seq_if b1 ();
  alu_ctrl_seq_if b3 ();

  alu_ctrl_seq #(.SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  alu_ctrl_seq #(.SETTLE(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  logic        sel;
  logic        valid_v, rr_v, junk;
  logic [5:0]  opc_v, fn_v;
  logic [15:0] imm_v;
  logic [31:0] rs_v, rt_v;

  assign b1.instr_valid = valid_v & ~sel;
  assign b3.instr_valid = valid_v & sel;
  assign b1.res_ready   = rr_v & ~sel;
  assign b3.res_ready   = rr_v & sel;
  assign b1.opcode = opc_v;  assign b3.opcode = opc_v;
  assign b1.funct  = fn_v;   assign b3.funct  = fn_v;
  assign b1.imm    = imm_v;  assign b3.imm    = imm_v;
  assign b1.rs_data = rs_v;  assign b3.rs_data = rs_v;
  assign b1.rt_data = rt_v;  assign b3.rt_data = rt_v;

  // Environment ALU; zero flag is meaningful only for op 0111.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  assign b1.alu_result = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);
  assign b3.alu_result = alu_f(b3.alu_op, b3.alu_a, b3.alu_b);
  assign b1.alu_zero = (b1.alu_op == 4'b0111) ? (b1.alu_a == b1.alu_b) : junk;
  assign b3.alu_zero = (b3.alu_op == 4'b0111) ? (b3.alu_a == b3.alu_b) : junk;

  logic        v_ready, v_res_valid, v_br, v_ill;
  logic [3:0]  v_op;
  logic [31:0] v_a, v_b, v_res;
  assign v_ready     = sel ? b3.instr_ready  : b1.instr_ready;
  assign v_res_valid = sel ? b3.res_valid    : b1.res_valid;
  assign v_br        = sel ? b3.branch_taken : b1.branch_taken;
  assign v_ill       = sel ? b3.illegal      : b1.illegal;
  assign v_op        = sel ? b3.alu_op       : b1.alu_op;
  assign v_a         = sel ? b3.alu_a        : b1.alu_a;
  assign v_b         = sel ? b3.alu_b        : b1.alu_b;
  assign v_res       = sel ? b3.result       : b1.result;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0]  last_op [2];
  logic [31:0] last_a  [2];
  logic [31:0] last_b  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: instruction semantics in plain arithmetic.
  function automatic void ref_model(input logic [5:0] opc, fn, input logic [15:0] imm,
                                    input logic [31:0] rs, rt,
                                    output logic [3:0] op, output logic [31:0] a, b, res,
                                    output logic br, ill);
    int simm;
    logic [31:0] zimm;
    simm = int'($signed(imm));
    zimm = 32'(imm);
    op = 4'b0000; a = rs; b = rt; res = 32'h0; br = 1'b0; ill = 1'b0;
    if (opc == 6'h00 && fn == 6'h24) begin op = 4'b0000; res = rs & rt; end
    else if (opc == 6'h00 && fn == 6'h25) begin op = 4'b0001; res = rs | rt; end
    else if (opc == 6'h00 && fn == 6'h20) begin op = 4'b0010; res = rs + rt; end
    else if (opc == 6'h00 && fn == 6'h22) begin op = 4'b0110; res = rs - rt; end
    else if (opc == 6'h23 || opc == 6'h2b) begin op = 4'b0010; b = 32'(simm); res = rs + 32'(simm); end
    else if (opc == 6'h0c) begin op = 4'b0000; b = zimm; res = rs & zimm; end
    else if (opc == 6'h0d) begin op = 4'b0001; b = zimm; res = rs | zimm; end
    else if (opc == 6'h04) begin op = 4'b0111; res = rs - rt; br = (rs == rt); end
    else ill = 1'b1;
  endfunction

  task automatic run_txn(input logic s, input int settle, input logic [5:0] opc, fn,
                         input logic [15:0] imm, input logic [31:0] rs, rt,
                         input logic [3:0] e_op, input logic [31:0] e_a, e_b, e_res,
                         input logic e_br, e_ill, input int hold, input string tag);
    int lat;
    int idx;
    idx = s ? 1 : 0;
    sel = s;
    junk = 1'($urandom);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(v_ready), 32'd1);
    valid_v = 1'b1; opc_v = opc; fn_v = fn; imm_v = imm; rs_v = rs; rt_v = rt;
    @(posedge clk);
    #1;
    valid_v = 1'b0;
    opc_v = 6'($urandom); fn_v = 6'($urandom); imm_v = 16'($urandom);
    rs_v = $urandom; rt_v = $urandom;
    if (!e_ill) begin
      last_op[idx] = e_op; last_a[idx] = e_a; last_b[idx] = e_b;
    end
    lat = 0;
    while (!v_res_valid && lat < 40) begin
      check({tag, "_exec_op"}, 32'(v_op), 32'(last_op[idx]));
      check({tag, "_exec_a"}, v_a, last_a[idx]);
      check({tag, "_exec_b"}, v_b, last_b[idx]);
      check({tag, "_exec_notready"}, 32'(v_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), e_ill ? 32'd0 : 32'(settle));
    check({tag, "_result"}, v_res, e_res);
    check({tag, "_branch"}, 32'(v_br), 32'(e_br));
    check({tag, "_illegal"}, 32'(v_ill), 32'(e_ill));
    check({tag, "_op_hold"}, 32'(v_op), 32'(last_op[idx]));
    check({tag, "_a_hold"}, v_a, last_a[idx]);
    check({tag, "_b_hold"}, v_b, last_b[idx]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_resp_valid"}, 32'(v_res_valid), 32'd1);
      check({tag, "_resp_result"}, v_res, e_res);
      check({tag, "_resp_notready"}, 32'(v_ready), 32'd0);
    end
    rr_v = 1'b1;
    @(posedge clk);
    #1;
    rr_v = 1'b0;
    check({tag, "_handoff_valid"}, 32'(v_res_valid), 32'd0);
    check({tag, "_handoff_ready"}, 32'(v_ready), 32'd1);
  endtask

  typedef struct {
    logic        s;
    logic [5:0]  opc, fn;
    logic [15:0] imm;
    logic [31:0] rs, rt;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        br, ill;
    int          hold;
  } vec_t;

  vec_t tbl [13];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res, rs, rt;
    logic [5:0]  opc, fn;
    logic [15:0] imm;
    logic        m_br, m_ill, s;

    tbl[0]  = '{1'b0, 6'h00, 6'h20, 16'h0000, 32'h1234_1234, 32'h1234_1234, 4'b0010, 32'h1234_1234, 32'h1234_1234, 32'h2468_2468, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 6'h04, 6'h00, 16'h0000, 32'h0000_00FF, 32'h0000_00FF, 4'b0111, 32'h0000_00FF, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b0, 6'h04, 6'h00, 16'h0000, 32'd5, 32'd3, 4'b0111, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 6'h23, 6'h00, 16'hFFFC, 32'h0000_1000, 32'h0, 4'b0010, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 6'h0D, 6'h00, 16'h8000, 32'h0, 32'h0, 4'b0001, 32'h0, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 6'h02, 6'h00, 16'h1234, 32'd1, 32'd2, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2};
    tbl[6]  = '{1'b1, 6'h00, 6'h22, 16'h0000, 32'd10, 32'd3, 4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 4};
    tbl[7]  = '{1'b0, 6'h00, 6'h24, 16'h0000, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1, 6'h0C, 6'h00, 16'h8F0F, 32'hFFFF_1234, 32'h0, 4'b0000, 32'hFFFF_1234, 32'h0000_8F0F, 32'h0000_0204, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 6'h2B, 6'h00, 16'h0008, 32'h0000_0100, 32'h0, 4'b0010, 32'h0000_0100, 32'h0000_0008, 32'h0000_0108, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b1, 6'h04, 6'h00, 16'h0000, 32'd7, 32'd7, 4'b0111, 32'd7, 32'd7, 32'h0, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b1, 6'h00, 6'h2A, 16'h0000, 32'd4, 32'd9, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    tbl[12] = '{1'b1, 6'h00, 6'h25, 16'h0000, 32'h0000_0F00, 32'h0000_00F0, 4'b0001, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b0, 0};

    sel = 1'b0; valid_v = 1'b0; rr_v = 1'b0; junk = 1'b0;
    opc_v = '0; fn_v = '0; imm_v = '0; rs_v = '0; rt_v = '0;
    for (int i = 0; i < 2; i++) begin last_op[i] = 4'h0; last_a[i] = 32'h0; last_b[i] = 32'h0; end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst1_ready", 32'(b1.instr_ready), 32'd1);
    check("rst1_valid", 32'(b1.res_valid), 32'd0);
    check("rst1_result", b1.result, 32'h0);
    check("rst1_op", 32'(b1.alu_op), 32'h0);
    check("rst3_ready", 32'(b3.instr_ready), 32'd1);
    check("rst3_illegal", 32'(b3.illegal), 32'd0);
    check("rst3_b", b3.alu_b, 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].s, tbl[i].s ? 3 : 1, tbl[i].opc, tbl[i].fn, tbl[i].imm, tbl[i].rs, tbl[i].rt,
              tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].br, tbl[i].ill, tbl[i].hold,
              $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      logic [5:0] opcs [8];
      logic [5:0] fns  [5];
      opcs = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h04, 6'($urandom)};
      fns  = '{6'h24, 6'h25, 6'h20, 6'h22, 6'($urandom)};
      s   = 1'($urandom);
      opc = opcs[$urandom_range(0, 7)];
      fn  = fns[$urandom_range(0, 4)];
      imm = 16'($urandom);
      rs  = $urandom;
      rt  = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      ref_model(opc, fn, imm, rs, rt, m_op, m_a, m_b, m_res, m_br, m_ill);
      run_txn(s, s ? 3 : 1, opc, fn, imm, rs, rt, m_op, m_a, m_b, m_res, m_br, m_ill,
              $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Reset while the SETTLE=3 instance is mid-EXEC: instruction is dropped.
    sel = 1'b1;
    @(negedge clk);
    valid_v = 1'b1; opc_v = 6'h00; fn_v = 6'h20; rs_v = 32'h1111_1111; rt_v = 32'h2222_2222;
    @(posedge clk);
    #1;
    valid_v = 1'b0;
    check("rstexec_in_exec", 32'(v_ready), 32'd0);
    reset = 1'b1;
    rr_v = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rstexec_ready", 32'(v_ready), 32'd1);
    check("rstexec_valid", 32'(v_res_valid), 32'd0);
    check("rstexec_result", v_res, 32'h0);
    check("rstexec_branch", 32'(v_br), 32'd0);
    check("rstexec_illegal", 32'(v_ill), 32'd0);
    check("rstexec_op", 32'(v_op), 32'h0);
    check("rstexec_a", v_a, 32'h0);
    check("rstexec_b", v_b, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("rstexec_no_resp", 32'(v_res_valid), 32'd0);
    end
    rr_v = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
